// File: rtl/approx_pkg.sv
// Shared definitions for the sequential approximation ALU: mode codes, FSM
// states and the saturation range check used on every result.
package approx_pkg;

  localparam logic [2:0] ALU_ADD_ONE  = 3'd0;
  localparam logic [2:0] ALU_SUB_ONE  = 3'd1;
  localparam logic [2:0] ALU_ADD_SUB  = 3'd2;
  localparam logic [2:0] ALU_MULTIPLY = 3'd3;
  localparam logic [2:0] ALU_IDLE     = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int SAT_W = 128;

  localparam logic [1:0] SAT_OK = 2'b00;
  localparam logic [1:0] SAT_HI = 2'b01;
  localparam logic [1:0] SAT_LO = 2'b10;

  // Classifies a wide signed value against the signed range of a w-bit word.
  function automatic logic [1:0] sat_dir(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = ~hi;
    if (v > hi) begin
      return SAT_HI;
    end else if (v < lo) begin
      return SAT_LO;
    end else begin
      return SAT_OK;
    end
  endfunction

endpackage

// File: rtl/approx_alu_seq_mul_u.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one partial product per step,
// multiplier consumed LSB first.
module seq_mul_u
  import approx_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               count_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // High in the cycle whose step is the final iteration, so the caller can
  // leave its iteration state on that same edge.
  assign count_done = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/approx_alu_seq.sv
// Sequential approximation ALU: single-cycle add/sub ops, WIDTH-cycle signed
// multiply, full-precision and saturated Q-format results with handshake.
module approx_alu_seq
  import approx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [2:0]                mode_i,
  input  logic                      sigma_n_i,
  input  logic [WIDTH-1:0]          op_a_i,
  input  logic [WIDTH-1:0]          op_b_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic signed [2*WIDTH-1:0] res_o,
  output logic signed [WIDTH-1:0]   res_q_o,
  output logic                      ovf_o
);

  localparam int W2 = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state;
  logic   sign_r;

  logic signed [W2-1:0] a_ext, b_ext, one_q, alu_sum, mul_signed, mul_shift;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [W2-1:0]        mul_prod;
  logic                 mul_load, mul_step, mul_last;
  logic [1:0]           dir_alu, dir_mul;
  logic signed [WIDTH-1:0] q_alu, q_mul;

  always_comb begin
    a_ext = {{WIDTH{op_a_i[WIDTH-1]}}, op_a_i};
    b_ext = {{WIDTH{op_b_i[WIDTH-1]}}, op_b_i};
    one_q = {{(W2-1){1'b0}}, 1'b1} << FRAC;
    case (mode_i)
      ALU_ADD_ONE: alu_sum = a_ext + one_q;
      ALU_SUB_ONE: alu_sum = a_ext - one_q;
      ALU_ADD_SUB: alu_sum = sigma_n_i ? (a_ext - b_ext) : (a_ext + b_ext);
      default:     alu_sum = {W2{1'b0}};
    endcase

    // Two's-complement negation of the most negative value yields 2^(WIDTH-1) as unsigned.
    abs_a = op_a_i[WIDTH-1] ? -op_a_i : op_a_i;
    abs_b = op_b_i[WIDTH-1] ? -op_b_i : op_b_i;

    mul_signed = sign_r ? -mul_prod : mul_prod;
    mul_shift  = mul_signed >>> FRAC;

    dir_alu = sat_dir(SAT_W'(alu_sum), WIDTH);
    dir_mul = sat_dir(SAT_W'(mul_shift), WIDTH);

    if (dir_alu == SAT_HI) begin
      q_alu = Q_MAX;
    end else if (dir_alu == SAT_LO) begin
      q_alu = Q_MIN;
    end else begin
      q_alu = alu_sum[WIDTH-1:0];
    end

    if (dir_mul == SAT_HI) begin
      q_mul = Q_MAX;
    end else if (dir_mul == SAT_LO) begin
      q_mul = Q_MIN;
    end else begin
      q_mul = mul_shift[WIDTH-1:0];
    end
  end

  assign mul_load = start_i && (state == IDLE) && (mode_i == ALU_MULTIPLY);
  assign mul_step = (state == MUL);

  seq_mul_u #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .load       (mul_load),
    .step       (mul_step),
    .a          (abs_a),
    .b          (abs_b),
    .prod       (mul_prod),
    .count_done (mul_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      res_o   <= '0;
      res_q_o <= '0;
      ovf_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (mode_i == ALU_MULTIPLY) begin
              sign_r <= op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
              busy_o <= 1'b1;
              state  <= MUL;
            end else begin
              res_o   <= alu_sum;
              res_q_o <= q_alu;
              ovf_o   <= (dir_alu != SAT_OK);
              done_o  <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            state <= FIN;
          end
        end
        FIN: begin
          res_o   <= mul_signed;
          res_q_o <= q_mul;
          ovf_o   <= (dir_mul != SAT_OK);
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
